// File: rtl/pe_pkg.sv
// Shared types and constants for the PE result path.
// Optional RESULT_CNT_EN support lives in pe_result_collector.
package pe_pkg;

    localparam int INT_BITS        = 7;
    localparam int FRAC_BITS       = 9;
    localparam int DATA_W          = INT_BITS + FRAC_BITS;
    localparam int NUM_ACC         = 8;
    localparam int IDX_W           = $clog2(NUM_ACC);
    localparam int PE_DEPTH        = 8;
    localparam int PE_STALL_MARGIN = 4;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } pe_result_t;

    // Accumulator slots cycle 0..NUM_ACC-1 and wrap.
    function automatic logic [IDX_W-1:0] next_slot(input logic [IDX_W-1:0] slot);
        logic [IDX_W-1:0] nxt;
        if (slot == IDX_W'(NUM_ACC - 1)) begin
            nxt = '0;
        end else begin
            nxt = slot + IDX_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pe_result_fifo.sv
// Generic synchronous FIFO with registered storage and a zero-latency head view.
// A push while full is accepted only when a pop happens in the same cycle.
module pe_result_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (level_r == LVL_FULL);
    assign empty     = (level_r == '0);
    assign level     = level_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Pointer and occupancy tracking; clr empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage write; contents survive clr since an empty head is don't-care.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s && !clr) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/pe_result_collector.sv
// Tags PE results with their accumulator slot, buffers them and drains over valid/ready.
// Define RESULT_CNT_EN to add a free-running count of accepted results (result_cnt).
import pe_pkg::*;

module pe_result_collector #(
    parameter int DEPTH        = PE_DEPTH,
    parameter int STALL_MARGIN = PE_STALL_MARGIN,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              keep_req,
    output logic              overflow,
    output logic [LVL_W-1:0]  level
`ifdef RESULT_CNT_EN
    ,
    output logic [31:0]       result_cnt
`endif
);

    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] KEEP_THR = LVL_W'(DEPTH - STALL_MARGIN);

    logic [IDX_W-1:0] slot_r;
    logic             overflow_r;
    logic             keep_r;
    logic             full_s;
    logic             empty_s;
    logic [LVL_W-1:0] level_s;
    logic             pop_s;
    logic             push_ok_s;
    logic             drop_s;
    logic [LVL_W-1:0] next_level_s;
    pe_result_t       wr_s;
    pe_result_t       head_s;

    assign wr_s.idx  = slot_r;
    assign wr_s.data = in_data;

    pe_result_fifo #(
        .WIDTH ($bits(pe_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (in_valid),
        .pop   (pop_s),
        .wdata (wr_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level_s)
    );

    assign out_valid = !empty_s;
    assign out_data  = head_s.data;
    assign out_idx   = head_s.idx;
    assign level     = level_s;
    assign keep_req  = keep_r;
    assign overflow  = overflow_r;

    // Acceptance: a full FIFO still takes a result if the head leaves this cycle.
    always_comb begin
        pop_s        = out_valid && out_ready;
        push_ok_s    = in_valid && (!full_s || pop_s);
        drop_s       = in_valid && full_s && !pop_s;
        next_level_s = level_s;
        case ({push_ok_s, pop_s})
            2'b10:   next_level_s = level_s + LVL_ONE;
            2'b01:   next_level_s = level_s - LVL_ONE;
            default: next_level_s = level_s;
        endcase
    end

    // Slot tag, sticky overflow and the look-ahead stall request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_r     <= '0;
            overflow_r <= 1'b0;
            keep_r     <= 1'b0;
        end else if (flush) begin
            slot_r     <= '0;
            overflow_r <= 1'b0;
            keep_r     <= 1'b0;
        end else begin
            if (push_ok_s) begin
                slot_r <= next_slot(slot_r);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            keep_r <= (next_level_s >= KEEP_THR);
        end
    end

`ifdef RESULT_CNT_EN
    logic [31:0] cnt_r;
    assign result_cnt = cnt_r;

    // Accepted-result counter; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 32'd0;
        end else if (flush) begin
            cnt_r <= 32'd0;
        end else if (push_ok_s) begin
            cnt_r <= cnt_r + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pe_result_collector.md
Name: pe_result_collector

Overview:
Downstream stage of the PE unit. Captures each rounded result the PE presents (data word plus valid strobe) and tags it with its accumulator-slot index. Buffers tagged results in a small FIFO and drains them to the writeback path over a valid/ready handshake. Drives a keep (stall) request back to the PE when the FIFO nears full, so no in-flight result is lost.

Parameters:
INT_BITS, 7, integer bits of a result word
FRAC_BITS, 9, fraction bits of a result word; DATA_W = INT_BITS + FRAC_BITS
NUM_ACC, 8, accumulator slots per PE; IDX_W = $clog2(NUM_ACC)
DEPTH, 8, FIFO entries (power of two, >= 4)
STALL_MARGIN, 4, free entries reserved for results already in the PE pipeline when keep_req rises

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  result strobe from PE (rounder_valid)
in_data  in  DATA_W  rounded result from PE (data_out)
flush  in  1  synchronous clear of FIFO, slot counter and overflow
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head entry
out_data  out  DATA_W  head result
out_idx  out  IDX_W  accumulator slot of head result
keep_req  out  1  stall request to PE (drives keep)
overflow  out  1  sticky: a result arrived while FIFO full
level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst high, async): FIFO empty, rd/wr pointers 0, slot counter 0, out_valid=0, out_data=0, out_idx=0, keep_req=0, overflow=0, level=0.
- Write: every clk edge with in_valid=1 is one result; write {slot, in_data} at wr_ptr, then slot <= (slot==NUM_ACC-1) ? 0 : slot+1. Slot advances only on accepted writes.
- Read: pop when out_valid && out_ready. out_data/out_idx show the head combinationally from the storage array (registered storage, zero-latency head view).
- Write latency: result written at edge N is visible on out_valid after edge N (cycle N+1).
- Simultaneous push and pop: both occur; level unchanged. This includes the full case: a push while full and popping the same cycle is accepted, with no overflow.
- Full (level==DEPTH) with in_valid and no pop: result dropped, slot not advanced, overflow <= 1 (sticky until flush or rst).
- Empty: out_valid=0. out_data/out_idx hold the last array contents and are don't-care.
- keep_req registered: keep_req <= (next_level >= DEPTH - STALL_MARGIN). Deasserts on the edge after next_level falls below the threshold.
- Pointers are IDX-free binary of width $clog2(DEPTH) and wrap modulo DEPTH. level is tracked by a separate counter.
- flush: on the next edge, the FIFO empties, slot=0, overflow=0, keep_req=0. flush overrides a same-cycle push or pop; any in_valid that cycle is discarded.
- rst asserted mid-transfer: all state clears immediately. out_valid drops asynchronously.

Optional Feature:
Macro RESULT_CNT_EN.
- Defined: adds output port result_cnt [31:0], counting accepted writes. It wraps at 2^32, clears on rst/flush, and does not count dropped results.
- Undefined: no port, no counter logic.
- All other behaviour is identical either way.

Decomposition:
- Shared package pe_pkg: localparams INT_BITS=7, FRAC_BITS=9, DATA_W, NUM_ACC=8, IDX_W; typedef pe_result_t packed struct {logic [IDX_W-1:0] idx; logic [DATA_W-1:0] data;}.
- One sub-module: pe_result_fifo. It is a generic sync FIFO parameterised on width/depth with push/pop/full/empty/level.
- The collector top holds the slot counter, keep_req, overflow and flush.

Test Plan:
- Reset then 8 single in_valid pulses, data 16'h0001..16'h0008, out_ready=1 -> outputs appear in order with out_idx 0..7, each one cycle after its write; level never exceeds 1.
- out_ready=0, 4 writes -> keep_req=1 on the edge after the 4th write (level=4, DEPTH-STALL_MARGIN=4). Drain 1 -> keep_req=0 the next edge.
- out_ready=0, 9 writes of 16'hA5A5 -> level=8, 9th dropped, overflow=1. Slot after the 8 accepted writes wraps to 0, so the next accepted write gets idx 0.
- Full FIFO with in_valid=1 and out_ready=1 the same cycle -> level stays 8, overflow stays 0, new entry is at the tail.
- 3 entries queued, flush=1 with in_valid=1 -> next cycle level=0, out_valid=0, overflow=0, next write tagged idx 0.
- rst asserted between edges while out_valid=1 -> out_valid=0 immediately, not waiting for a clk edge. With RESULT_CNT_EN defined, after 10 accepted + 2 dropped writes, result_cnt=10.
